// File: rtl/seg7_pkg.sv
// Shared glyph constants (active-low, seg[6]=a .. seg[0]=g), FSM state type
// and anode helpers for the seven-segment scan decoder.
package seg7_pkg;

  localparam logic [6:0] GLYPH_0     = 7'b0000001;
  localparam logic [6:0] GLYPH_1     = 7'b1001111;
  localparam logic [6:0] GLYPH_2     = 7'b0010010;
  localparam logic [6:0] GLYPH_3     = 7'b0000110;
  localparam logic [6:0] GLYPH_4     = 7'b1001100;
  localparam logic [6:0] GLYPH_5     = 7'b0100100;
  localparam logic [6:0] GLYPH_6     = 7'b0100000;
  localparam logic [6:0] GLYPH_7     = 7'b0001111;
  localparam logic [6:0] GLYPH_8     = 7'b0000000;
  localparam logic [6:0] GLYPH_9     = 7'b0000100;
  localparam logic [6:0] GLYPH_A     = 7'b0001000;
  localparam logic [6:0] GLYPH_B     = 7'b1100000;
  localparam logic [6:0] GLYPH_C     = 7'b0110001;
  localparam logic [6:0] GLYPH_D     = 7'b1000010;
  localparam logic [6:0] GLYPH_E     = 7'b0110000;
  localparam logic [6:0] GLYPH_F     = 7'b0111000;
  localparam logic [6:0] GLYPH_BLANK = 7'b1111111;

  typedef enum logic {
    TRACK = 1'b0,
    HELD  = 1'b1
  } state_e;

  function automatic logic is_onehot4(input logic [3:0] v);
    return (v != 4'h0) && ((v & (v - 4'd1)) == 4'h0);
  endfunction

  // Only meaningful for a one-hot selector; other inputs map to slot 0.
  function automatic logic [1:0] anode_index(input logic [3:0] sel);
    case (sel)
      4'b0010: return 2'd1;
      4'b0100: return 2'd2;
      4'b1000: return 2'd3;
      default: return 2'd0;
    endcase
  endfunction

endpackage

// File: rtl/seg7_glyph_decode.sv
// Combinational glyph-to-value decode with blank/error flags.
// Define SEG7_HEX_EN to also accept the A-F glyphs.
module seg7_glyph_decode
  import seg7_pkg::*;
(
  input  logic [6:0] seg,
  output logic [3:0] value,
  output logic       blank,
  output logic       err
);

  always_comb begin
    value = 4'h0;
    blank = 1'b0;
    err   = 1'b0;
    case (seg)
      GLYPH_0:     value = 4'h0;
      GLYPH_1:     value = 4'h1;
      GLYPH_2:     value = 4'h2;
      GLYPH_3:     value = 4'h3;
      GLYPH_4:     value = 4'h4;
      GLYPH_5:     value = 4'h5;
      GLYPH_6:     value = 4'h6;
      GLYPH_7:     value = 4'h7;
      GLYPH_8:     value = 4'h8;
      GLYPH_9:     value = 4'h9;
`ifdef SEG7_HEX_EN
      GLYPH_A:     value = 4'hA;
      GLYPH_B:     value = 4'hB;
      GLYPH_C:     value = 4'hC;
      GLYPH_D:     value = 4'hD;
      GLYPH_E:     value = 4'hE;
      GLYPH_F:     value = 4'hF;
`endif
      GLYPH_BLANK: blank = 1'b1;
      default:     err   = 1'b1;
    endcase
  end

endmodule

// File: rtl/seg7_scan_decoder.sv
// Recovers a 4-digit frame from a multiplexed active-low 7-segment drive.
// Define SEG7_HEX_EN to decode A-F glyphs (otherwise they flag err).
module seg7_scan_decoder
  import seg7_pkg::*;
#(
  parameter int STABLE_CYCLES = 4
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [3:0]  an,
  input  logic [6:0]  seg,
  output logic [15:0] digits,
  output logic [3:0]  blank,
  output logic [3:0]  err,
  output logic        frame_valid
);

  localparam logic [7:0] STABLE_N = 8'(STABLE_CYCLES);

  logic [3:0]       an_q;
  logic [6:0]       seg_q;
  logic [10:0]      prev_q;
  logic [7:0]       cnt_q, cnt_d;
  state_e           state_q;
  logic [3:0]       mask_q, mask_d;
  logic [15:0]      digits_q;
  logic [3:0]       blank_q, err_q;
  logic             frame_valid_q;
  logic [3:0][3:0]  slot_val_q;
  logic [3:0]       slot_blk_q, slot_err_q;

  logic [3:0] sel;
  logic       qual, same, capture, frame_done;
  logic [1:0] idx;
  logic [3:0] dec_value;
  logic       dec_blank, dec_err;

  seg7_glyph_decode u_dec (
    .seg   (seg_q),
    .value (dec_value),
    .blank (dec_blank),
    .err   (dec_err)
  );

  // prev_q tracks every sample, so a disqualified one can never match the next.
  assign sel        = ~an_q;
  assign qual       = is_onehot4(sel);
  assign same       = qual && ({an_q, seg_q} == prev_q);
  assign idx        = anode_index(sel);
  assign frame_done = (mask_q == 4'hF);

  always_comb begin
    cnt_d = 8'd0;
    if (qual) begin
      if (!same)                cnt_d = 8'd1;
      else if (cnt_q == 8'hFF)  cnt_d = cnt_q;
      else                      cnt_d = cnt_q + 8'd1;
    end
  end

  assign capture = (state_q == TRACK) && qual && (cnt_d == STABLE_N);

  // A capture on the frame-completion edge lands in the freshly cleared mask.
  always_comb begin
    mask_d = frame_done ? 4'h0 : mask_q;
    if (capture) mask_d[idx] = 1'b1;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      an_q          <= 4'hF;
      seg_q         <= 7'h7F;
      prev_q        <= {4'hF, 7'h7F};
      cnt_q         <= 8'd0;
      state_q       <= TRACK;
      mask_q        <= 4'h0;
      digits_q      <= 16'h0000;
      blank_q       <= 4'hF;
      err_q         <= 4'h0;
      frame_valid_q <= 1'b0;
    end else begin
      an_q          <= an;
      seg_q         <= seg;
      prev_q        <= {an_q, seg_q};
      cnt_q         <= cnt_d;
      mask_q        <= mask_d;
      frame_valid_q <= frame_done;
      case (state_q)
        TRACK:   if (capture) state_q <= HELD;
        HELD:    if (!same)   state_q <= TRACK;
        default:              state_q <= TRACK;
      endcase
      if (frame_done) begin
        digits_q <= slot_val_q;
        blank_q  <= slot_blk_q;
        err_q    <= slot_err_q;
      end
    end
  end

  // Slot storage is pure data; the mask alone decides when it is valid.
  always_ff @(posedge clk) begin
    if (capture) begin
      slot_val_q[idx] <= dec_value;
      slot_blk_q[idx] <= dec_blank;
      slot_err_q[idx] <= dec_err;
    end
  end

  assign digits      = digits_q;
  assign blank       = blank_q;
  assign err         = err_q;
  assign frame_valid = frame_valid_q;

endmodule

// File: tb/tb_seg7_scan_decoder.sv
// Directed bench for seg7_scan_decoder with a run-length reference model.
module tb_seg7_scan_decoder;

  localparam int S = 4;

  logic        clk = 1'b0;
  logic        rst;
  logic [3:0]  an;
  logic [6:0]  seg;
  logic [15:0] digits;
  logic [3:0]  blank;
  logic [3:0]  err;
  logic        frame_valid;

  int vectors     = 0;
  int miscompares = 0;
  int fv_count    = 0;

  always #5 clk = ~clk;

  seg7_scan_decoder #(.STABLE_CYCLES(S)) dut (
    .clk         (clk),
    .rst         (rst),
    .an          (an),
    .seg         (seg),
    .digits      (digits),
    .blank       (blank),
    .err         (err),
    .frame_valid (frame_valid)
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference: returns {blank, err, value} for an active-low glyph.
  function automatic logic [5:0] ref_decode(input logic [6:0] p);
    case (p)
      7'b0000001: return 6'h00;
      7'b1001111: return 6'h01;
      7'b0010010: return 6'h02;
      7'b0000110: return 6'h03;
      7'b1001100: return 6'h04;
      7'b0100100: return 6'h05;
      7'b0100000: return 6'h06;
      7'b0001111: return 6'h07;
      7'b0000000: return 6'h08;
      7'b0000100: return 6'h09;
`ifdef SEG7_HEX_EN
      7'b0001000: return 6'h0A;
      7'b1100000: return 6'h0B;
      7'b0110001: return 6'h0C;
      7'b1000010: return 6'h0D;
      7'b0110000: return 6'h0E;
      7'b0111000: return 6'h0F;
`endif
      7'b1111111: return 6'h20;
      default:    return 6'h10;
    endcase
  endfunction

  // Model: a run of S identical one-hot samples yields one capture the edge
  // after the run completes; a full mask publishes the frame one edge later.
  logic [10:0] m_prev;
  int          m_run;
  logic        m_pend;
  int          m_pend_idx;
  logic [6:0]  m_pend_seg;
  logic [3:0]  m_sv [4];
  logic [3:0]  m_sb, m_se, m_mask;
  logic        m_full;
  logic [15:0] m_digits;
  logic [3:0]  m_blank, m_err;
  logic        m_fv;

  always @(posedge clk) begin
    logic [5:0] d;
    logic       ok;
    if (rst) begin
      m_prev = 11'h7FF; m_run = 0; m_pend = 1'b0; m_pend_idx = 0; m_pend_seg = 7'h7F;
      m_mask = 4'h0; m_full = 1'b0; m_digits = 16'h0; m_blank = 4'hF; m_err = 4'h0;
      m_fv = 1'b0; m_sb = 4'h0; m_se = 4'h0;
      for (int i = 0; i < 4; i++) m_sv[i] = 4'h0;
    end else begin
      m_fv = m_full;
      if (m_full) begin
        m_digits = {m_sv[3], m_sv[2], m_sv[1], m_sv[0]};
        m_blank  = m_sb;
        m_err    = m_se;
        m_mask   = 4'h0;
      end
      if (m_pend) begin
        d = ref_decode(m_pend_seg);
        m_sv[m_pend_idx] = d[3:0];
        m_se[m_pend_idx] = d[4];
        m_sb[m_pend_idx] = d[5];
        m_mask[m_pend_idx] = 1'b1;
      end
      m_full = (m_mask == 4'hF);
      ok = ($countones(~an) == 1);
      if (!ok)                           m_run = 0;
      else if ({an, seg} == m_prev)      m_run = m_run + 1;
      else                               m_run = 1;
      m_prev = {an, seg};
      m_pend = ok && (m_run == S);
      m_pend_seg = seg;
      for (int i = 0; i < 4; i++) if (!an[i]) m_pend_idx = i;
    end
  end

  always @(negedge clk) begin
    if (!rst) begin
      chk("cyc_digits", 32'(digits), 32'(m_digits));
      chk("cyc_blank", 32'(blank), 32'(m_blank));
      chk("cyc_err", 32'(err), 32'(m_err));
      chk("cyc_fv", 32'(frame_valid), 32'(m_fv));
      chk("cyc_mask", 32'(dut.mask_q), 32'(m_mask));
    end
  end

  always @(posedge clk) if (frame_valid) fv_count++;

  task automatic hold(input logic [3:0] a, input logic [6:0] s, input int n);
    an  = a;
    seg = s;
    repeat (n) @(negedge clk);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1);
  end

  initial begin
    int f0, cyc;
    rst = 1'b1; an = 4'hF; seg = 7'h7F;
    repeat (3) @(negedge clk);
    chk("rst_digits", 32'(digits), 32'h0);
    chk("rst_blank", 32'(blank), 32'hF);
    chk("rst_err", 32'(err), 32'h0);
    chk("rst_fv", 32'(frame_valid), 32'h0);
    chk("rst_cnt", 32'(dut.cnt_q), 32'h0);
    chk("rst_mask", 32'(dut.mask_q), 32'h0);
    rst = 1'b0;
    @(negedge clk);

    // Basic frame 9013 and completion latency
    f0 = fv_count;
    hold(4'b1110, 7'b0000110, 6);
    hold(4'b1101, 7'b1001111, 6);
    hold(4'b1011, 7'b0000001, 6);
    chk("mask3", 32'(dut.mask_q), 32'h7);
    an = 4'b0111; seg = 7'b0000100; cyc = 0;
    while (!frame_valid && cyc < 20) begin
      @(negedge clk);
      cyc++;
    end
    chk("latency", 32'(cyc), 32'(S + 2));
    hold(4'hF, 7'h7F, 4);
    chk("f1_count", 32'(fv_count - f0), 32'd1);
    chk("f1_digits", 32'(digits), 32'h9013);
    chk("f1_blank", 32'(blank), 32'h0);
    chk("f1_err", 32'(err), 32'h0);

    // Held one cycle short of the threshold: no capture
    hold(4'b1110, 7'b0100100, S - 1);
    hold(4'hF, 7'h7F, 3);
    chk("short_mask", 32'(dut.mask_q), 32'h0);

    // Two anodes active: nothing qualifies
    hold(4'b1100, 7'b0000001, 10);
    chk("multi_cnt", 32'(dut.cnt_q), 32'h0);
    chk("multi_mask", 32'(dut.mask_q), 32'h0);
    hold(4'hF, 7'h7F, 2);

    // Blank and error glyphs
    f0 = fv_count;
    hold(4'b1110, 7'b0000000, 6);
    hold(4'b1101, 7'b0001111, 6);
    hold(4'b1011, 7'b1111111, 6);
    hold(4'b0111, 7'b1010101, 6);
    hold(4'hF, 7'h7F, 4);
    chk("f2_count", 32'(fv_count - f0), 32'd1);
    chk("f2_digits", 32'(digits), 32'h0078);
    chk("f2_blank", 32'(blank), 32'b0100);
    chk("f2_err", 32'(err), 32'b1000);

    // Long hold captured once, then slot 0 overwritten
    f0 = fv_count;
    hold(4'b1110, 7'b0100100, 14);
    hold(4'b1110, 7'b0100000, 6);
    chk("recap_mask", 32'(dut.mask_q), 32'h1);
    hold(4'b1101, 7'b0010010, 6);
    hold(4'b1011, 7'b1001100, 6);
    hold(4'b0111, 7'b0001111, 6);
    hold(4'hF, 7'h7F, 4);
    chk("f3_count", 32'(fv_count - f0), 32'd1);
    chk("f3_digits", 32'(digits), 32'h7426);

    // Hex glyph A on digit 0
    f0 = fv_count;
    hold(4'b1110, 7'b0001000, 6);
    hold(4'b1101, 7'b1001111, 6);
    hold(4'b1011, 7'b0010010, 6);
    hold(4'b0111, 7'b0000110, 6);
    hold(4'hF, 7'h7F, 4);
    chk("f4_count", 32'(fv_count - f0), 32'd1);
`ifdef SEG7_HEX_EN
    chk("f4_digits", 32'(digits), 32'h321A);
    chk("f4_err", 32'(err), 32'h0);
`else
    chk("f4_digits", 32'(digits), 32'h3210);
    chk("f4_err", 32'(err), 32'h1);
`endif
    chk("f4_blank", 32'(blank), 32'h0);

    // Reset mid-frame discards the partial frame
    f0 = fv_count;
    hold(4'b1110, 7'b0000000, 6);
    hold(4'b1101, 7'b0000000, 6);
    hold(4'b1011, 7'b0000000, 6);
    chk("part_mask", 32'(dut.mask_q), 32'h7);
    rst = 1'b1;
    @(negedge clk);
    chk("rst2_mask", 32'(dut.mask_q), 32'h0);
    rst = 1'b0;
    hold(4'b0111, 7'b0000000, 6);
    hold(4'hF, 7'h7F, 4);
    chk("f5_count", 32'(fv_count - f0), 32'd0);
    chk("f5_mask", 32'(dut.mask_q), 32'b1000);
    chk("f5_digits", 32'(digits), 32'h0);
    chk("f5_blank", 32'(blank), 32'hF);
    chk("f5_err", 32'(err), 32'h0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/seg7_scan_decoder.md
SEG7_SCAN_DECODER -- requirements
Module: seg7_scan_decoder

Interface
REQ-001 The block SHALL have parameter STABLE_CYCLES, default 4 (range 2..255): consecutive identical samples required before a digit is captured.
REQ-002 The block SHALL have port clk, input, 1 bit: the single clock; every register SHALL be clocked on its rising edge.
REQ-003 The block SHALL have port rst, input, 1 bit: asynchronous, active-high reset.
REQ-004 The block SHALL have port an, input, 4 bits: active-low digit enables of a scanned display; an[i]=0 selects digit i.
REQ-005 The block SHALL have port seg, input, 7 bits: active-low segments, seg[6]=a through seg[0]=g.
REQ-006 The block SHALL have port digits, output, 16 bits: decoded frame, digit i in digits[4i+3:4i].
REQ-007 The block SHALL have port blank, output, 4 bits: blank[i]=1 when digit i showed the all-off pattern.
REQ-008 The block SHALL have port err, output, 4 bits: err[i]=1 when digit i showed an undecodable pattern.
REQ-009 The block SHALL have port frame_valid, output, 1 bit: one-cycle pulse when digits, blank and err update.

Function
REQ-010 The block SHALL register an and seg through one input sample stage (an_q, seg_q) before any decision logic.
REQ-011 A sample SHALL be qualified only when ~an_q is one-hot; zero or multiple active anodes SHALL clear the stability counter and SHALL capture nothing.
REQ-012 The stability counter SHALL increment, saturating, while the qualified {an_q,seg_q} equals the previous sample, and SHALL reload to 1 on any change.
REQ-013 The FSM SHALL have states TRACK (counting) and HELD (captured, waiting for a change); reset state SHALL be TRACK.
REQ-014 In TRACK, when the counter reaches STABLE_CYCLES, the block SHALL capture the pattern into slot i, set mask[i], and go to HELD.
REQ-015 In HELD, any change of {an_q,seg_q}, or a disqualified sample, SHALL return the FSM to TRACK, so each held pattern is captured exactly once.
REQ-016 Decode SHALL map 0000001->0, 1001111->1, 0010010->2, 0000110->3, 1001100->4, 0100100->5, 0100000->6, 0001111->7, 0000000->8, 0000100->9.
REQ-017 Pattern 1111111 SHALL decode to value 0 with blank flag 1; any other unlisted pattern SHALL decode to value 0 with err flag 1.
REQ-018 Recapture of a slot whose mask bit is already set SHALL overwrite that slot's value and flags.
REQ-019 When a capture completes mask=1111, on the next edge the block SHALL copy all four slots to digits/blank/err, pulse frame_valid high for one cycle, and clear mask.
REQ-020 A capture on the same edge that mask is cleared SHALL be retained in the new mask.
REQ-021 Latency from the input edge presenting the completing pattern to frame_valid SHALL be STABLE_CYCLES+2 clocks.
REQ-022 Outputs SHALL hold their values between frame_valid pulses.

Reset
REQ-023 Reset SHALL asynchronously set digits=0, blank=4'b1111, err=0, frame_valid=0, mask=0, counter=0, state TRACK, an_q=4'hF and seg_q=7'h7F.
REQ-024 Assertion of rst mid-frame SHALL discard the partial frame; no frame_valid SHALL occur until four new captures follow deassertion.

Configuration
REQ-025 With macro SEG7_HEX_EN defined, decode SHALL also map 0001000->A, 1100000->B, 0110001->C, 1000010->D, 0110000->E, 0111000->F with err=0.
REQ-026 Without SEG7_HEX_EN, those six patterns SHALL be treated as errors under REQ-017.

Structure
REQ-027 A shared package seg7_pkg SHALL hold the active-low glyph constants (0-9, A-F, BLANK) and the FSM state typedef.
REQ-028 The glyph-to-value decode SHALL be a combinational sub-module, seg7_glyph_decode (seg in; value, blank, err out), honouring SEG7_HEX_EN.

Verification
REQ-029 The bench SHALL hold an=1110/0000110, 1101/1001111, 1011/0000001 and 0111/0000100 for 6 clocks each, expecting one frame_valid with digits=16'h9013, blank=0 and err=0.
REQ-030 The bench SHALL hold a pattern for exactly STABLE_CYCLES-1 clocks, then change it, expecting no mask bit set.
REQ-031 The bench SHALL apply an=1100 with any seg for 10 clocks, expecting no capture and the counter at 0.
REQ-032 The bench SHALL drive digit 2 with 1111111 and digit 3 with 1010101 in a full frame, expecting blank=0100 and err=1000.
REQ-033 The bench SHALL apply pattern 0001000 on digit 0, expecting digits[3:0]=4'hA with err[0]=0 when SEG7_HEX_EN is defined, and err[0]=1 otherwise.
REQ-034 The bench SHALL pulse rst after three captures and then complete one digit, expecting no frame_valid and outputs at reset values.
